// File: rtl/usbf_gnrl_pipe.sv
// -----------------------------------------------------------------------------
// usbf_gnrl_pipe
//
// Parametrised DEPTH-stage valid/ready register pipeline used to retime
// USB packet-engine and buffer-interface paths without losing data under
// backpressure. Bubbles collapse: a stage accepts a word whenever it is
// empty or its successor is accepting. A synchronous flush clears every
// valid bit, and a registered occupancy count is provided.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous clear of all valid bits (data registers untouched)
//   in_valid   upstream word valid
//   in_data    upstream word (DW bits)
//   in_ready   pipeline accepts in_data this cycle
//   out_valid  last stage holds a word
//   out_data   data of the last stage
//   out_ready  downstream accepts out_data this cycle
//   count      number of valid stages, 0..DEPTH (CW bits)
//   empty      count == 0
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module usbf_gnrl_pipe #(
    parameter int            DW        = 32,
    parameter int            DEPTH     = 2,
    parameter logic [DW-1:0] RESET_VAL = {DW{1'b0}},
    localparam int           CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("usbf_gnrl_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] r_vld;
    logic [DW-1:0]    r_dat [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_src_vld;
    logic [DW-1:0]    w_src_dat [DEPTH];
    logic [DEPTH-1:0] w_vld_nxt;
    logic [DEPTH-1:0] w_load;
    logic [CW-1:0]    w_count_nxt;

    // Each stage is fed by its predecessor; stage 0 is fed by the input port.
    assign w_src_vld[0] = in_valid;
    assign w_src_dat[0] = in_data;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_src
        assign w_src_vld[gi] = r_vld[gi-1];
        assign w_src_dat[gi] = r_dat[gi-1];
    end

    // Advance chain walks from the output back to the input, so a bubble
    // anywhere downstream lets every stage above it move.
    always_comb begin
        logic w_a;
        w_a = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_a      = !r_vld[i] | w_a;
            w_adv[i] = w_a;
        end
    end

    // Next-state valid bits, data load enables and occupancy.
    // Data only loads a real word, so bubbles never disturb the registers
    // and in_data is ignored while in_valid is low.
    always_comb begin
        w_vld_nxt   = '0;
        w_load      = '0;
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                w_vld_nxt[i] = 1'b0;
            end else if (w_adv[i]) begin
                w_vld_nxt[i] = w_src_vld[i];
            end else begin
                w_vld_nxt[i] = r_vld[i];
            end
            w_load[i]   = !flush & w_adv[i] & w_src_vld[i];
            w_count_nxt = w_count_nxt + CW'(w_vld_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= RESET_VAL;
            end
        end else begin
            r_vld   <= w_vld_nxt;
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_dat[i] <= w_src_dat[i];
                end
            end
        end
    end

    assign in_ready  = w_adv[0] & !flush;
    assign out_valid = r_vld[DEPTH-1];
    assign out_data  = r_dat[DEPTH-1];
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));

endmodule

// File: doc/usbf_gnrl_pipe.md
Name: usbf_gnrl_pipe

Overview:
- Parametrised DEPTH-stage valid/ready register pipeline. It is the next-generation replacement for the single load-enabled flops in the general primitive library.
- Each stage holds one DW-bit word and a valid bit. Bubbles collapse, so a stage accepts data whenever it is empty or its successor is accepting.
- Carries a synchronous flush and an occupancy count.
- Used to retime USB packet-engine and buffer-interface paths without data loss under backpressure.

Parameters:
- DW, 32, data width in bits (>=1).
- DEPTH, 2, number of register stages (>=1; DEPTH=0 is illegal and must fail elaboration).
- RESET_VAL, {DW{1'b0}}, reset value of every stage data register.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not to be overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  upstream word valid.
- in_data  in  DW  upstream word.
- in_ready  out  1  pipeline accepts in_data this cycle.
- out_valid  out  1  stage DEPTH-1 holds a word.
- out_data  out  DW  data of stage DEPTH-1.
- out_ready  in  1  downstream accepts out_data this cycle.
- count  out  CW  number of valid stages, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- State: vld[i], dat[i] for i=0..DEPTH-1. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Reset (rst=1, asynchronous): all vld=0, all dat=RESET_VAL. Resulting outputs: out_valid=0, out_data=RESET_VAL, count=0, empty=1, full=0, in_ready=1 (unless flush=1).
- Advance terms (combinational):
  - adv[DEPTH-1] = !vld[DEPTH-1] | out_ready.
  - adv[i] = !vld[i] | adv[i+1].
- in_ready = adv[0] & !flush. The ready chain is combinational through all stages; this is an accepted timing cost.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Per stage, each rising edge, when flush=0:
  - If adv[i]: vld[i] <= src_vld, where src_vld = in_valid for i=0 and vld[i-1] otherwise.
  - dat[i] loads src_dat only when adv[i] & src_vld. Data registers never load bubbles, so dat holds its last value when vld=0.
  - If !adv[i]: vld[i] and dat[i] hold.
- Flush=1: all vld <= 0 at the next edge. dat is unchanged. in_ready=0, so no input transfer occurs. An output transfer can still complete that cycle (out_valid & out_ready); the word is consumed and not replayed.
- Latency: a word accepted into an empty pipeline appears on out_valid exactly DEPTH cycles later.
- Throughput: 1 word/cycle sustained with out_ready held high.
- Ordering: strict FIFO; no word is dropped or duplicated except on flush.
- count: registered. count <= popcount of next-state vld. On flush it goes to 0 at the next edge. empty and full decode from count.
- Full with out_ready=0: in_ready=0 and all state holds.
- Full with out_ready=1: in_ready=1; simultaneous in and out transfers leave count unchanged.
- Stable backpressure: out_data must not change while out_valid=1 and out_ready=0.
- Reset mid-stream: all contents are lost immediately. No output transfer is reported in the reset cycle.
- X-safety: in_data is never sampled when in_valid=0.

Test Plan (DW=8, DEPTH=3, RESET_VAL=8'hA5 unless noted):
1. Assert rst, release; hold in_valid=0 → out_valid=0, out_data=8'hA5, count=0, empty=1, in_ready=1.
2. Present 8'h11 one cycle with out_ready=1 → out_valid=1, out_data=8'h11 exactly 3 cycles later; count goes 1,1,1 then 0 after consumption.
3. Stream 8'h01..8'h0A back-to-back with out_ready=1 → same sequence output in order, one per cycle, in_ready constantly 1.
4. out_ready=0, push 8'h21, 8'h22, 8'h23, 8'h24 → first three accepted, count=3, full=1, in_ready=0; 8'h24 is held upstream. Raise out_ready → output 21, 22, 23, 24 in order; out_data stable while stalled.
5. Pipeline full with 3 words; pulse flush with in_valid=1, out_ready=0 → in_ready=0 that cycle; next cycle count=0, out_valid=0; the input word is not accepted.
6. Two words in flight; assert rst asynchronously mid-cycle → out_valid drops immediately, out_data=8'hA5, count=0. Repeat for DEPTH=1: latency 1, throughput 1/cycle with out_ready=1.
